// File: rtl/sd_spi_arbiter.sv
// sd_spi_arbiter: shares one SPI-mode SD card between the init, read and write engines.
// Optional build macro SD_ARB_TIMEOUT_EN bounds ownership to TIMEOUT_CLKS cycles.
module sd_spi_arbiter #(
    parameter int GAP_CLKS     = 8,
    parameter int TIMEOUT_CLKS = 65535
) (
    input  logic       SD_clk,
    input  logic       rst_n,
    input  logic       init_done,
    input  logic [2:0] req,
    input  logic [2:0] cs_i,
    input  logic [2:0] din_i,
    output logic [2:0] gnt,
    output logic [2:0] dout_o,
    output logic       SD_cs,
    output logic       SD_datain,
    input  logic       SD_dataout,
    output logic       busy,
    output logic       timeout_err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [7:0] GAP_LAST = 8'(GAP_CLKS - 1);

    if (GAP_CLKS < 1 || GAP_CLKS > 255 || TIMEOUT_CLKS < 2 || TIMEOUT_CLKS > 65535) begin : g_bad_cfg
        $error("sd_spi_arbiter: GAP_CLKS or TIMEOUT_CLKS out of range");
    end

    logic [1:0] state;
    logic [7:0] gap_cnt;
    logic       rr_wr;
    logic [2:0] avail;
    logic [2:0] elig;
    logic [2:0] pick;
    logic       own_req;
    logic       to_hit;

    // Pins follow the owner combinationally; with no owner the card sees CS high and idle MOSI.
    assign SD_cs     = |gnt ? |(gnt & cs_i)  : 1'b1;
    assign SD_datain = |gnt ? |(gnt & din_i) : 1'b1;
    assign dout_o    = ~gnt | {3{SD_dataout}};
    assign busy      = state != IDLE;
    assign own_req   = |(gnt & req);

    // Init always wins; read/write alternate, favouring whichever was not granted last.
    always_comb begin
        elig = req & avail & {init_done, init_done, 1'b1};
        pick = elig[0] ? 3'b001 :
               (elig[1] & elig[2]) ? (rr_wr ? 3'b010 : 3'b100) :
               elig[1] ? 3'b010 :
               elig[2] ? 3'b100 : 3'b000;
    end

`ifdef SD_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CLKS - 1);
    logic [15:0] own_cnt;
    logic [2:0]  stale;

    assign avail  = ~stale;
    assign to_hit = (state == OWN) && own_req && (own_cnt == TO_LAST);

    // Ownership watchdog: a forced release marks the owner stale until it lets go of req.
    always_ff @(posedge SD_clk or negedge rst_n) begin
        if (!rst_n) begin
            own_cnt     <= '0;
            stale       <= '0;
            timeout_err <= 1'b0;
        end else begin
            own_cnt     <= (state == OWN) ? own_cnt + 16'd1 : 16'd0;
            stale       <= (stale & req) | (to_hit ? gnt : 3'b000);
            timeout_err <= to_hit;
        end
    end
`else
    assign avail       = 3'b111;
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // IDLE -> OWN on any eligible request, OWN -> GAP on release, GAP -> IDLE after GAP_CLKS cycles.
    always_ff @(posedge SD_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            gap_cnt <= '0;
            rr_wr   <= 1'b1;
        end else begin
            case (state)
                IDLE: if (|pick) begin
                    gnt   <= pick;
                    state <= OWN;
                    if (pick[1] | pick[2]) rr_wr <= pick[2];
                end
                OWN: if (!own_req || to_hit) begin
                    gnt     <= '0;
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: if (gap_cnt == GAP_LAST) begin
                    gap_cnt <= '0;
                    state   <= IDLE;
                end else begin
                    gap_cnt <= gap_cnt + 8'd1;
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
